// File: rtl/jtpopeye_sdram_pkg.sv
// Shared definitions for the Popeye SDRAM read arbiter.
//   state_t : arbiter sequencing states (IDLE/REQ/WAIT)
//   owner_t : which requester owns the fetch in flight (MAIN=0, OBJ=1)
//   DEF_*_OFFSET : default SDRAM word base address of each ROM region
//   word_addr() : maps a cache tag (32-bit word index) to an SDRAM
//                 16-bit word address inside a region
package jtpopeye_sdram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_MAIN = 1'b0,
    OWN_OBJ  = 1'b1
  } owner_t;

  localparam logic [21:0] DEF_MAIN_OFFSET = 22'h00000;
  localparam logic [21:0] DEF_OBJ_OFFSET  = 22'h04000;

  // One 32-bit word spans two 16-bit SDRAM words, hence the trailing zero.
  // The sum wraps modulo 2^22.
  function automatic logic [21:0] word_addr(input logic [21:0] base,
                                            input logic [12:0] tag);
    return base + {8'd0, tag, 1'b0};
  endfunction

endpackage

// File: rtl/jtpopeye_sdram_slot.sv
// One-word tag cache for a single SDRAM requester.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : synchronous invalidate; also forces ok low
//   cs         : requester read strobe (level)
//   tag        : 32-bit word index currently requested
//   bsel       : byte lane inside the word (used when DW=8)
//   fill       : write fill_tag/fill_data into the slot and mark it valid
//   fill_tag   : tag of the word being written (the tag of the fetch,
//                not necessarily the one currently requested)
//   fill_data  : 32-bit word from SDRAM
//   miss       : cs is high and the slot does not hold the requested word
//   ok         : registered; dout is valid for the current request
//   dout       : registered read data, byte (DW=8) or full word (DW=32)
module jtpopeye_sdram_slot #(
  parameter int TW = 13,
  parameter int DW = 32
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          cs,
  input  logic [TW-1:0] tag,
  input  logic [1:0]    bsel,
  input  logic          fill,
  input  logic [TW-1:0] fill_tag,
  input  logic [31:0]   fill_data,
  output logic          miss,
  output logic          ok,
  output logic [DW-1:0] dout
);

  logic          valid;
  logic [TW-1:0] tag_q;
  logic [31:0]   word_q;
  logic          hit;
  logic [DW-1:0] sel;

  assign hit  = valid && (tag_q == tag);
  assign miss = cs && !hit;

  generate
    if (DW == 8) begin : g_byte
      // Byte 0 lives in bits 7:0.
      assign sel = word_q[{bsel, 3'b000} +: 8];
    end else begin : g_word
      assign sel = word_q >> {bsel, 3'b000};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= 1'b0;
      tag_q  <= '0;
      word_q <= '0;
      ok     <= 1'b0;
      dout   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ok    <= 1'b0;
    end else begin
      if (fill) begin
        valid  <= 1'b1;
        tag_q  <= fill_tag;
        word_q <= fill_data;
      end
      // ok follows the hit with one cycle of latency; a fill becomes
      // visible on ok the cycle after it is written.
      ok <= cs && hit;
      if (cs && hit) dout <= sel;
    end
  end

endmodule

// File: rtl/jtpopeye_sdram_arb.sv
// SDRAM read-port arbiter for the Popeye main CPU ROM and OBJ ROM.
//   clk, rst           : 20 MHz clock, asynchronous active-high reset
//   downloading        : ROM download active; aborts and flushes, clears ready
//   loop_rst           : controller loop reset; aborts and flushes
//   main_cs/addr/dout/ok : main CPU byte reads (15-bit byte address)
//   obj_cs/addr/dout/ok  : OBJ 32-bit word reads (13-bit word address)
//   ready              : set the cycle after a download ends
//   sdram_req/addr     : read request to the controller (16-bit word address)
//   sdram_ack          : controller accepted the request (1-cycle pulse)
//   data_rdy/data_read : read data strobe and 32-bit data
//   refresh_en         : controller may refresh (arbiter idle, nothing pending)
//
// Handshake: sdram_req rises with sdram_addr and both stay constant until
// the cycle sdram_ack is sampled high, when sdram_req drops. The read data
// is taken on the first data_rdy pulse at or after that ack; a data_rdy in
// the same cycle as the ack completes the transfer immediately. data_rdy
// pulses outside an outstanding request are ignored.
module jtpopeye_sdram_arb
  import jtpopeye_sdram_pkg::*;
#(
  parameter logic [21:0] MAIN_OFFSET = DEF_MAIN_OFFSET,
  parameter logic [21:0] OBJ_OFFSET  = DEF_OBJ_OFFSET
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic        loop_rst,
  input  logic        main_cs,
  input  logic [14:0] main_addr,
  output logic [7:0]  main_dout,
  output logic        main_ok,
  input  logic        obj_cs,
  input  logic [12:0] obj_addr,
  output logic [31:0] obj_dout,
  output logic        obj_ok,
  output logic        ready,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        data_rdy,
  input  logic [31:0] data_read,
  output logic        refresh_en
);

  state_t      state;
  owner_t      owner;
  owner_t      last_grant;
  logic [12:0] fetch_tag;
  logic        dl_q;

  logic        abort;
  logic        main_miss;
  logic        obj_miss;
  logic        grant_main;
  logic        grant_obj;
  logic        fill;
  logic        main_fill;
  logic        obj_fill;

  assign abort = downloading | loop_rst;

  // Round robin only matters on a tie: MAIN wins unless it was served last.
  assign grant_main = main_miss && (!obj_miss || (last_grant == OWN_OBJ));
  assign grant_obj  = obj_miss && !grant_main;

  assign fill = !abort && data_rdy &&
                ((state == ST_WAIT) || ((state == ST_REQ) && sdram_ack));
  assign main_fill = fill && (owner == OWN_MAIN);
  assign obj_fill  = fill && (owner == OWN_OBJ);

  jtpopeye_sdram_slot #(.TW(13), .DW(8)) u_main (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .cs        (main_cs),
    .tag       (main_addr[14:2]),
    .bsel      (main_addr[1:0]),
    .fill      (main_fill),
    .fill_tag  (fetch_tag),
    .fill_data (data_read),
    .miss      (main_miss),
    .ok        (main_ok),
    .dout      (main_dout)
  );

  jtpopeye_sdram_slot #(.TW(13), .DW(32)) u_obj (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .cs        (obj_cs),
    .tag       (obj_addr),
    .bsel      (2'b00),
    .fill      (obj_fill),
    .fill_tag  (fetch_tag),
    .fill_data (data_read),
    .miss      (obj_miss),
    .ok        (obj_ok),
    .dout      (obj_dout)
  );

  // ready rises on the cycle after downloading falls and holds until the
  // next download or reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_q  <= 1'b0;
      ready <= 1'b0;
    end else begin
      dl_q <= downloading;
      if (downloading)  ready <= 1'b0;
      else if (dl_q)    ready <= 1'b1;
    end
  end

  // Request sequencer. fetch_tag remembers the tag the fetch was issued
  // for, so a requester that moves on mid-fetch still gets the fetched
  // word filed under the right tag; its new miss is handled from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_MAIN;
      last_grant <= OWN_OBJ;
      fetch_tag  <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      refresh_en <= 1'b1;
    end else if (abort) begin
      state      <= ST_IDLE;
      sdram_req  <= 1'b0;
      refresh_en <= 1'b0;
    end else begin
      refresh_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_main) begin
            owner      <= OWN_MAIN;
            fetch_tag  <= main_addr[14:2];
            sdram_addr <= word_addr(MAIN_OFFSET, main_addr[14:2]);
            sdram_req  <= 1'b1;
            state      <= ST_REQ;
          end else if (grant_obj) begin
            owner      <= OWN_OBJ;
            fetch_tag  <= obj_addr;
            sdram_addr <= word_addr(OBJ_OFFSET, obj_addr);
            sdram_req  <= 1'b1;
            state      <= ST_REQ;
          end else begin
            // Refresh is only offered after a full idle cycle with no miss.
            refresh_en <= 1'b1;
          end
        end
        ST_REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            if (data_rdy) begin
              last_grant <= owner;
              state      <= ST_IDLE;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (data_rdy) begin
            last_grant <= owner;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          sdram_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtpopeye_sdram_arb.sv
// Bench for jtpopeye_sdram_arb: an SDRAM controller model with a random
// memory image answers requests with programmable ack/data delays; the
// directed sequence and a randomized phase compare outputs against values
// computed from the memory image and the address mapping.
module tb_jtpopeye_sdram_arb;
  import jtpopeye_sdram_pkg::*;

  localparam logic [21:0] MAIN_OFF = 22'h00000;
  localparam logic [21:0] OBJ_OFF  = 22'h04000;

  logic        clk;
  logic        rst;
  logic        downloading;
  logic        loop_rst;
  logic        main_cs;
  logic [14:0] main_addr;
  logic [7:0]  main_dout;
  logic        main_ok;
  logic        obj_cs;
  logic [12:0] obj_addr;
  logic [31:0] obj_dout;
  logic        obj_ok;
  logic        ready;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_rdy;
  logic [31:0] data_read;
  logic        refresh_en;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] mem [0:32767];
  logic [21:0] req_log [$];
  int          ack_dly = 1;
  int          rdy_dly = 1;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #25 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  jtpopeye_sdram_arb dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .loop_rst    (loop_rst),
    .main_cs     (main_cs),
    .main_addr   (main_addr),
    .main_dout   (main_dout),
    .main_ok     (main_ok),
    .obj_cs      (obj_cs),
    .obj_addr    (obj_addr),
    .obj_dout    (obj_dout),
    .obj_ok      (obj_ok),
    .ready       (ready),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .data_rdy    (data_rdy),
    .data_read   (data_read),
    .refresh_en  (refresh_en)
  );

  // ---------------- reference helpers ----------------
  function automatic logic [31:0] mem_word(input logic [21:0] a);
    logic [14:0] lo;
    lo = a[14:0];
    return {mem[lo + 15'd1], mem[lo]};
  endfunction

  function automatic logic [21:0] exp_main_word(input logic [14:0] a);
    return MAIN_OFF + 22'(a / 15'd4) * 22'd2;
  endfunction

  function automatic logic [21:0] exp_obj_word(input logic [12:0] a);
    return OBJ_OFF + 22'(a) * 22'd2;
  endfunction

  function automatic logic [7:0] exp_main_byte(input logic [14:0] a);
    logic [31:0] d;
    d = mem_word(exp_main_word(a));
    return d[8 * int'(a % 15'd4) +: 8];
  endfunction

  // ---------------- SDRAM controller model ----------------
  initial begin : controller
    int          phase;
    int          cnt;
    logic [21:0] a;
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    data_read = '0;
    phase = 0;
    cnt   = 0;
    a     = '0;
    forever begin
      @(posedge clk);
      #1;
      sdram_ack = 1'b0;
      data_rdy  = 1'b0;
      data_read = $urandom;
      if (rst || loop_rst || downloading) begin
        phase = 0;
      end else begin
        case (phase)
          0: if (sdram_req) begin
            a = sdram_addr;
            req_log.push_back(a);
            cnt   = ack_dly - 1;
            phase = 1;
          end
          1: if (cnt == 0) begin
            sdram_ack = 1'b1;
            if (rdy_dly == 0) begin
              data_rdy  = 1'b1;
              data_read = mem_word(a);
              phase     = 0;
            end else begin
              cnt   = rdy_dly - 1;
              phase = 2;
            end
          end else cnt--;
          default: if (cnt == 0) begin
            data_rdy  = 1'b1;
            data_read = mem_word(a);
            phase     = 0;
          end else cnt--;
        endcase
      end
    end
  end

  // ---------------- scoreboard / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 = sdram_ack, 1 = data_rdy, 2 = sdram_req
  task automatic wait_sig(input int which, input int budget, output bit got);
    got = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if ((which == 0 && sdram_ack === 1'b1) ||
          (which == 1 && data_rdy === 1'b1) ||
          (which == 2 && sdram_req === 1'b1)) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ok(input bit want_main, input bit want_obj, input int budget,
                         output bit got);
    got = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if ((!want_main || main_ok === 1'b1) && (!want_obj || obj_ok === 1'b1)) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin : stimulus
    bit          got;
    int          sel;
    int          n0;
    bit          efm;
    bit          efo;
    bit          m_known;
    bit          o_known;
    int          m_tag;
    int          o_tag;
    bit          match;
    logic [14:0] ma;
    logic [12:0] oa;

    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[2] = 16'hBBAA;
    mem[3] = 16'hDDCC;

    rst = 1'b1; downloading = 1'b0; loop_rst = 1'b0;
    main_cs = 1'b0; main_addr = '0; obj_cs = 1'b0; obj_addr = '0;

    // Reset values, before any clock edge.
    #10;
    check("rst_sdram_req",  32'(sdram_req), 32'd0);
    check("rst_sdram_addr", 32'(sdram_addr), 32'd0);
    check("rst_main_dout",  32'(main_dout), 32'd0);
    check("rst_obj_dout",   obj_dout, 32'd0);
    check("rst_oks",        32'({main_ok, obj_ok}), 32'd0);
    check("rst_ready",      32'(ready), 32'd0);
    check("rst_refresh",    32'(refresh_en), 32'd1);
    check("rst_state",      32'(dut.state), 32'(ST_IDLE));

    @(negedge clk);
    rst = 1'b0;
    downloading = 1'b1;
    tick(3);
    check("dl_ready_low",   32'(ready), 32'd0);
    check("dl_refresh_low", 32'(refresh_en), 32'd0);
    downloading = 1'b0;
    tick(1);
    check("ready_after_dl", 32'(ready), 32'd1);
    tick(2);
    check("idle_req",     32'(sdram_req), 32'd0);
    check("idle_refresh", 32'(refresh_en), 32'd1);

    // Simultaneous misses: MAIN first after reset, then OBJ.
    ack_dly = 2; rdy_dly = 2;
    req_log.delete();
    main_cs = 1'b1; main_addr = 15'h0000;
    obj_cs  = 1'b1; obj_addr  = 13'h0010;
    tick(1);
    check("tie_refresh_low", 32'(refresh_en), 32'd0);
    wait_ok(1'b1, 1'b1, 80, got);
    check("tie_timeout", 32'(got), 32'd1);
    check("tie_nreq", 32'(req_log.size()), 32'd2);
    if (req_log.size() >= 2) begin
      check("tie_first_addr",  32'(req_log[0]), 32'h000000);
      check("tie_second_addr", 32'(req_log[1]), 32'h004020);
    end
    check("tie_main_dout", 32'(main_dout), 32'(exp_main_byte(15'h0000)));
    check("tie_obj_dout",  obj_dout, mem_word(22'h004020));
    main_cs = 1'b0; obj_cs = 1'b0;
    tick(1);
    check("cs_drop_oks", 32'({main_ok, obj_ok}), 32'd0);

    // Directed main miss with fixed controller timing.
    ack_dly = 3; rdy_dly = 5;
    req_log.delete();
    main_cs = 1'b1; main_addr = 15'h0005;
    wait_sig(1, 40, got);
    check("miss_data_timeout", 32'(got), 32'd1);
    check("miss_nreq", 32'(req_log.size()), 32'd1);
    if (req_log.size() >= 1) check("miss_addr", 32'(req_log[0]), 32'h000002);
    tick(1);
    check("miss_ok_at_fill", 32'(main_ok), 32'd0);
    tick(1);
    check("miss_ok_after_fill", 32'(main_ok), 32'd1);
    check("miss_dout", 32'(main_dout), 32'h000000BB);

    // Hit in the same word, then leaving the word.
    main_cs = 1'b0;
    tick(1);
    check("hit_cs_low_ok", 32'(main_ok), 32'd0);
    main_cs = 1'b1; main_addr = 15'h0006;
    tick(1);
    check("hit_ok",   32'(main_ok), 32'd1);
    check("hit_dout", 32'(main_dout), 32'h000000CC);
    check("hit_nreq", 32'(req_log.size()), 32'd1);
    check("hit_req",  32'(sdram_req), 32'd0);
    main_addr = 15'h0008;
    tick(1);
    check("leave_word_ok", 32'(main_ok), 32'd0);
    main_cs = 1'b0;
    tick(30);

    // loop_rst while waiting for data: abort, flush, refetch.
    ack_dly = 2; rdy_dly = 8;
    req_log.delete();
    main_cs = 1'b1; main_addr = 15'h0100;
    wait_sig(0, 20, got);
    check("lr_ack_timeout", 32'(got), 32'd1);
    tick(1);
    check("lr_in_wait", 32'(dut.state), 32'(ST_WAIT));
    loop_rst = 1'b1;
    tick(1);
    check("lr_req",     32'(sdram_req), 32'd0);
    check("lr_state",   32'(dut.state), 32'(ST_IDLE));
    check("lr_oks",     32'({main_ok, obj_ok}), 32'd0);
    check("lr_refresh", 32'(refresh_en), 32'd0);
    loop_rst = 1'b0;
    wait_ok(1'b1, 1'b0, 40, got);
    check("lr_refetch_timeout", 32'(got), 32'd1);
    check("lr_nreq", 32'(req_log.size()), 32'd2);
    if (req_log.size() >= 2) check("lr_refetch_addr", 32'(req_log[1]), 32'h000080);
    check("lr_dout", 32'(main_dout), 32'(exp_main_byte(15'h0100)));
    main_cs = 1'b0;
    tick(2);

    // Randomized reads; the model only remembers the last word each
    // requester fetched, and that a flush forgot the OBJ word.
    m_known = 1'b1; m_tag = 32'h40;
    o_known = 1'b0; o_tag = 0;
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(1, 3);
      ma  = ($urandom_range(0, 1) != 0) ? 15'($urandom_range(0, 31)) : 15'($urandom);
      oa  = ($urandom_range(0, 1) != 0) ? 13'($urandom_range(0, 7))  : 13'($urandom);
      ack_dly = $urandom_range(1, 4);
      rdy_dly = $urandom_range(0, 5);
      efm = sel[0] && !(m_known && m_tag == int'(ma >> 2));
      efo = sel[1] && !(o_known && o_tag == int'(oa));
      n0  = req_log.size();
      main_addr = ma; obj_addr = oa;
      main_cs = sel[0]; obj_cs = sel[1];
      wait_ok(sel[0], sel[1], 100, got);
      check("rnd_timeout", 32'(got), 32'd1);
      if (sel[0]) check("rnd_main_dout", 32'(main_dout), 32'(exp_main_byte(ma)));
      if (sel[1]) check("rnd_obj_dout", obj_dout, mem_word(exp_obj_word(oa)));
      check("rnd_nreq", 32'(req_log.size() - n0), 32'(int'(efm) + int'(efo)));
      for (int j = n0; j < req_log.size(); j++) begin
        match = (efm && req_log[j] == exp_main_word(ma)) ||
                (efo && req_log[j] == exp_obj_word(oa));
        check("rnd_req_addr", 32'(match), 32'd1);
      end
      if (sel[0]) begin m_known = 1'b1; m_tag = int'(ma >> 2); end
      if (sel[1]) begin o_known = 1'b1; o_tag = int'(oa); end
      main_cs = 1'b0; obj_cs = 1'b0;
      tick($urandom_range(1, 3));
    end

    // Asynchronous reset while a request is outstanding.
    ack_dly = 10; rdy_dly = 2;
    ma = 15'h0200;
    if (m_known && m_tag == int'(ma >> 2)) ma = 15'h0204;
    main_cs = 1'b1; main_addr = ma;
    wait_sig(2, 10, got);
    check("areset_req_high", 32'(got), 32'd1);
    #5 rst = 1'b1;
    #1;
    check("areset_req",     32'(sdram_req), 32'd0);
    check("areset_addr",    32'(sdram_addr), 32'd0);
    check("areset_oks",     32'({main_ok, obj_ok}), 32'd0);
    check("areset_douts",   32'(main_dout) | obj_dout, 32'd0);
    check("areset_ready",   32'(ready), 32'd0);
    check("areset_refresh", 32'(refresh_en), 32'd1);
    check("areset_state",   32'(dut.state), 32'(ST_IDLE));
    @(negedge clk);
    main_cs = 1'b0;
    rst = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jtpopeye_sdram_arb.md
Name: jtpopeye_sdram_arb

Overview:
- Shares the single SDRAM read port between two requesters: the main CPU ROM fetch (byte-wide, 32 kB) and the OBJ graphics fetch (32-bit words, 32 kB).
- Holds a one-word tag cache per requester, so repeated reads to the same 32-bit word finish without an SDRAM access.
- Sequences request, acknowledge and data-ready cycles, and gates refresh to idle periods.
- Sits between the game top level and the SDRAM controller, replacing direct per-client SDRAM access.

Parameters:
- MAIN_OFFSET, 22'h00000, SDRAM word (16-bit) base address of the main ROM region.
- OBJ_OFFSET, 22'h04000, SDRAM word base address of the OBJ ROM region.

Ports:
- clk  in  1  system clock (20 MHz domain).
- rst  in  1  asynchronous, active-high reset.
- downloading  in  1  ROM download in progress; suspends arbitration.
- loop_rst  in  1  SDRAM controller loop reset; synchronous abort and cache flush.
- main_cs  in  1  main CPU ROM read request (level).
- main_addr  in  15  main CPU byte address.
- main_dout  out  8  main CPU read data.
- main_ok  out  1  main_dout valid for the current main_addr.
- obj_cs  in  1  OBJ read request (level).
- obj_addr  in  13  OBJ 32-bit word address.
- obj_dout  out  32  OBJ read data.
- obj_ok  out  1  obj_dout valid for the current obj_addr.
- ready  out  1  high once the download has ended and the arbiter is operational.
- sdram_req  out  1  SDRAM read request.
- sdram_addr  out  22  SDRAM word address.
- sdram_ack  in  1  controller accepted the request (one-cycle pulse).
- data_rdy  in  1  data_read valid (one-cycle pulse).
- data_read  in  32  SDRAM read data; the word at sdram_addr is in the low half.
- refresh_en  out  1  controller may run refresh.

Behaviour:
- Reset values:
  - sdram_req=0, sdram_addr=0, main_dout=0, obj_dout=0.
  - main_ok=0, obj_ok=0, ready=0, refresh_en=1.
  - Both cache valid bits =0; state=IDLE; last_grant=OBJ, so MAIN wins the first tie.
- Address mapping:
  - Main fetch word: MAIN_OFFSET + {main_addr[14:2],1'b0}.
  - OBJ fetch word: OBJ_OFFSET + {obj_addr,1'b0}.
  - Sums are 22-bit and wrap modulo 2^22.
- Caches:
  - Main: tag main_addr[14:2] plus 32-bit word. Hit means valid and tag match; then main_dout = word byte selected by main_addr[1:0] (0 = bits 7:0).
  - OBJ: tag obj_addr plus 32-bit word.
  - Hit latency: main_ok/obj_ok are registered, rising one clk after cs is asserted with a hitting address.
  - ok drops in the same registered cycle the address leaves the cached word, or when cs drops.
- State machine:
  - IDLE: examine misses. If only one requester misses, grant it. If both miss, grant the one not in last_grant (round robin). On grant, load sdram_addr, set sdram_req=1, latch the owner, go to REQ. With no miss, stay in IDLE.
  - REQ: hold sdram_req and sdram_addr stable until sdram_ack=1. Then clear sdram_req and go to WAIT.
  - WAIT: on data_rdy=1, write data_read to the owner's cache, set the owner's tag and valid bit, update last_grant, go to IDLE.
  - The owner's ok asserts the cycle after cache fill if its address still matches.
- data_rdy seen in REQ together with sdram_ack: treat as ack followed by data, i.e. complete the fill directly.
- Requester changes address mid-fetch: the fetch completes and fills the cache with the old tag; the new miss is arbitrated next from IDLE. No cancellation.
- refresh_en=1 only in IDLE with no pending miss; otherwise 0.
- downloading=1:
  - Force IDLE, sdram_req=0, ready=0, both ok=0, both valid bits cleared, refresh_en=0.
  - On the downloading falling edge, ready=1 on the next clk and stays high until reset or the next download.
- loop_rst=1: same abort and flush as downloading, but ready is unaffected.
- Reset asserted mid-transaction: everything returns immediately to the reset values; the controller side is expected to be reset in parallel.
- Throughput: the miss-to-ok path is 1 (grant) + ack wait + data wait + 1 (fill) + 1 (ok) clk.

Decomposition:
- Shared package jtpopeye_sdram_pkg holds:
  - state encoding IDLE/REQ/WAIT;
  - owner encoding MAIN=0, OBJ=1;
  - default region offsets.
- One sub-module, jtpopeye_sdram_slot, instantiated twice with a tag-width parameter. It contains the tag, valid bit, data word, hit compare, registered ok and byte select.

Test Plan:
- Reset then downloading pulse 1→0 → ready=1 one clk later; sdram_req=0 and refresh_en=1 with no cs.
- main_cs=1, main_addr=15'h0005; controller acks 3 clk later, data_rdy 5 clk later with data_read=32'hDDCCBBAA → sdram_addr=22'h00002; main_dout=8'hBB with main_ok=1 one clk after data_rdy.
- Follow-up main_addr=15'h0006 → hit: main_dout=8'hCC, main_ok one clk later, no sdram_req.
- main_cs and obj_cs (obj_addr=13'h0010) both miss in the same cycle → MAIN is granted first (sdram_addr=22'h00000). OBJ follows with sdram_addr=22'h04020, and obj_dout equals its data_read.
- loop_rst pulse while in WAIT → sdram_req=0, state IDLE, both ok=0. A later read of the same address refetches from SDRAM.
- Async rst asserted in REQ with sdram_req=1 → sdram_req=0 and all outputs at reset values without waiting for a clk edge.
